// File: rtl/game_ctrl.sv
// Game-state controller: round-robin ghost collision scan, lives tracking and
// the IDLE/PLAY/PAUSE/DYING/OVER/WIN sequencer driving freeze/respawn.
module game_ctrl #(
    parameter int N_GHOSTS    = 4,
    parameter int LIVES       = 3,
    parameter int LW          = 3,
    parameter int HIT_R       = 16,
    parameter int DEATH_TICKS = 60
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic                    start,
    input  logic                    pause_req,
    input  logic                    all_eaten,
    input  logic [9:0]              pac_x,
    input  logic [9:0]              pac_y,
    input  logic [10*N_GHOSTS-1:0]  ghost_x,
    input  logic [9*N_GHOSTS-1:0]   ghost_y,
    output logic [2:0]              state,
    output logic [LW-1:0]           lives,
    output logic                    freeze,
    output logic                    respawn,
    output logic                    over,
    output logic                    win,
    output logic [2:0]              hit_idx
);

    localparam int CW = $clog2(DEATH_TICKS + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PLAY  = 3'd1,
        S_PAUSE = 3'd2,
        S_DYING = 3'd3,
        S_OVER  = 3'd4,
        S_WIN   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic            hit_q, hit_d;
    logic [2:0]      hit_id_q, hit_id_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            respawn_q, respawn_d;
    logic            freeze_q, freeze_d;
    logic            over_q, over_d;
    logic            win_q, win_d;
    logic [2:0]      hit_idx_q, hit_idx_d;

    logic [9:0]      gx, gy, dx, dy;

    // One ghost per cycle; y is zero-extended so both axes compare at 10 bits.
    always_comb begin
        gx = '0;
        gy = '0;
        for (int unsigned i = 0; i < N_GHOSTS; i++) begin
            if (idx_q == 3'(i)) begin
                gx = ghost_x[10*i +: 10];
                gy = {1'b0, ghost_y[9*i +: 9]};
            end
        end
        dx       = (pac_x >= gx) ? (pac_x - gx) : (gx - pac_x);
        dy       = (pac_y >= gy) ? (pac_y - gy) : (gy - pac_y);
        hit_d    = (dx < 10'(HIT_R)) && (dy < 10'(HIT_R));
        hit_id_d = idx_q;
        idx_d    = (idx_q == 3'(N_GHOSTS - 1)) ? '0 : idx_q + 3'd1;
    end

    always_comb begin
        state_d   = state_q;
        lives_d   = lives_q;
        cnt_d     = cnt_q;
        hit_idx_d = hit_idx_q;
        respawn_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_PLAY;
                    lives_d   = LW'(LIVES);
                    respawn_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (all_eaten) begin
                    state_d = S_WIN;
                end else if (hit_q) begin
                    state_d   = S_DYING;
                    lives_d   = (lives_q != '0) ? lives_q - LW'(1) : '0;
                    hit_idx_d = hit_id_q;
                    cnt_d     = '0;
                end else if (pause_req) begin
                    state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (start) begin
                    state_d   = S_PLAY;
                    lives_d   = LW'(LIVES);
                    respawn_d = 1'b1;
                end else if (pause_req) begin
                    state_d = S_PLAY;
                end
            end
            S_DYING: begin
                // Exit on the tick that brings the count to DEATH_TICKS.
                if (tick) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(DEATH_TICKS - 1)) begin
                        if (lives_q == '0) begin
                            state_d = S_OVER;
                        end else begin
                            state_d   = S_PLAY;
                            respawn_d = 1'b1;
                        end
                    end
                end
            end
            S_OVER, S_WIN: begin
                if (start) begin
                    state_d   = S_PLAY;
                    lives_d   = LW'(LIVES);
                    respawn_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        freeze_d = (state_d != S_PLAY);
        over_d   = (state_d == S_OVER);
        win_d    = (state_d == S_WIN);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            hit_id_q  <= '0;
            lives_q   <= LW'(LIVES);
            cnt_q     <= '0;
            respawn_q <= 1'b0;
            freeze_q  <= 1'b1;
            over_q    <= 1'b0;
            win_q     <= 1'b0;
            hit_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            hit_id_q  <= hit_id_d;
            lives_q   <= lives_d;
            cnt_q     <= cnt_d;
            respawn_q <= respawn_d;
            freeze_q  <= freeze_d;
            over_q    <= over_d;
            win_q     <= win_d;
            hit_idx_q <= hit_idx_d;
        end
    end

    assign state   = state_q;
    assign lives   = lives_q;
    assign freeze  = freeze_q;
    assign respawn = respawn_q;
    assign over    = over_q;
    assign win     = win_q;
    assign hit_idx = hit_idx_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with default parameters (4 ghosts, 3 lives, 60 death ticks).
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst, tick, start, pause_req, all_eaten;
    logic [9:0]  pac_x, pac_y;
    logic [39:0] ghost_x;
    logic [35:0] ghost_y;
    logic [2:0]  state;
    logic [2:0]  lives;
    logic        freeze, respawn, over, win;
    logic [2:0]  hit_idx;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    game_ctrl #(
        .N_GHOSTS(4), .LIVES(3), .LW(3), .HIT_R(16), .DEATH_TICKS(60)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .pause_req(pause_req),
        .all_eaten(all_eaten), .pac_x(pac_x), .pac_y(pac_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y), .state(state), .lives(lives),
        .freeze(freeze), .respawn(respawn), .over(over), .win(win), .hit_idx(hit_idx)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_x[10*i +: 10] = 10'(x);
        ghost_y[9*i +: 9]   = 9'(y);
    endtask

    task automatic ghosts_home();
        for (int i = 0; i < 4; i++) set_ghost(i, 600, 400);
    endtask

    task automatic do_tick();
        tick = 1'b1; step();
        tick = 1'b0; step();
    endtask

    // Ghost 2 overlaps at (+15,-15); DYING must be reached within 5 cycles,
    // then 59 ticks hold DYING and the 60th exits to exp_state.
    task automatic die(input string tag, input int exp_lives, input int exp_state);
        set_ghost(2, 115, 85);
        repeat (5) step();
        check({tag, "_dying"}, state, 3);
        check({tag, "_lives"}, lives, exp_lives);
        check({tag, "_hit_idx"}, hit_idx, 2);
        ghosts_home();
        repeat (59) do_tick();
        check({tag, "_hold59"}, state, 3);
        tick = 1'b1; step(); tick = 1'b0;
        check({tag, "_exit"}, state, exp_state);
        check({tag, "_respawn"}, respawn, (exp_state == 1) ? 1 : 0);
        step();
        check({tag, "_respawn_off"}, respawn, 0);
    endtask

    initial begin
        int bad;
        rst = 1'b0; tick = 1'b0; start = 1'b0; pause_req = 1'b0; all_eaten = 1'b0;
        pac_x = 10'd10; pac_y = 10'd10;
        ghost_x = '0; ghost_y = '0;
        ghosts_home();
        step(); step();
        check("rst_state", state, 0);
        check("rst_lives", lives, 3);
        check("rst_freeze", freeze, 1);
        check("rst_flags", {respawn, over, win}, 0);
        check("rst_hit_idx", hit_idx, 0);

        rst = 1'b1; step();
        start = 1'b1; step(); start = 1'b0;
        check("start_state", state, 1);
        check("start_lives", lives, 3);
        check("start_respawn", respawn, 1);
        check("start_freeze", freeze, 0);
        step();
        check("start_respawn_pulse", respawn, 0);

        bad = 0;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (state != 3'd1) bad++;
        end
        check("no_hit_far", bad, 0);

        // Boundary: distance exactly HIT_R on one axis is not a hit.
        pac_x = 10'd100; pac_y = 10'd100;
        set_ghost(1, 116, 100);
        set_ghost(3, 100, 116);
        repeat (20) step();
        check("edge_dx16", state, 1);
        ghosts_home();
        step(); step();

        die("d1", 2, 1);
        die("d2", 1, 1);
        die("d3", 0, 4);
        check("over_flag", over, 1);
        check("over_freeze", freeze, 1);

        bad = 0;
        set_ghost(2, 100, 100);
        for (int k = 0; k < 10000; k++) begin
            tick      = (k % 3 == 0);
            pause_req = (k % 7 == 0);
            all_eaten = (k % 11 == 0);
            step();
            if (state != 3'd4 || over != 1'b1) bad++;
        end
        tick = 1'b0; pause_req = 1'b0; all_eaten = 1'b0;
        ghosts_home();
        check("over_sticky", bad, 0);
        step();
        start = 1'b1; step(); start = 1'b0;
        check("restart_state", state, 1);
        check("restart_lives", lives, 3);
        check("restart_respawn", respawn, 1);
        check("restart_over", over, 0);
        step();

        // all_eaten arriving with hit_q already set: WIN wins.
        for (int i = 0; i < 4; i++) set_ghost(i, 100, 100);
        step();
        check("pre_win_play", state, 1);
        all_eaten = 1'b1; step(); all_eaten = 1'b0;
        check("win_state", state, 5);
        check("win_flag", win, 1);
        check("win_lives", lives, 3);
        ghosts_home();
        step(); step();
        start = 1'b1; step(); start = 1'b0;
        check("win_restart", state, 1);
        step();

        pause_req = 1'b1; step(); pause_req = 1'b0;
        check("pause_state", state, 2);
        check("pause_freeze", freeze, 1);
        set_ghost(2, 100, 100);
        repeat (20) step();
        check("pause_no_death", state, 2);
        check("pause_lives", lives, 3);
        ghosts_home();
        step(); step();
        pause_req = 1'b1; step(); pause_req = 1'b0;
        check("resume_state", state, 1);
        check("resume_freeze", freeze, 0);
        check("resume_no_respawn", respawn, 0);

        // hit_q together with pause_req: death takes priority.
        for (int i = 0; i < 4; i++) set_ghost(i, 100, 100);
        step();
        pause_req = 1'b1; step(); pause_req = 1'b0;
        check("hit_vs_pause", state, 3);
        check("hit_vs_pause_lives", lives, 2);
        ghosts_home();

        repeat (3) do_tick();
        rst = 1'b0; step();
        check("mid_dying_rst_state", state, 0);
        check("mid_dying_rst_lives", lives, 3);
        check("mid_dying_rst_flags", {respawn, over, win, hit_idx}, 0);
        check("mid_dying_rst_freeze", freeze, 1);
        rst = 1'b1; step();

        start = 1'b1; step(); start = 1'b0;
        step();
        pause_req = 1'b1; step();
        check("pause2_state", state, 2);
        start = 1'b1; step(); start = 1'b0; pause_req = 1'b0;
        check("pause_restart_state", state, 1);
        check("pause_restart_respawn", respawn, 1);
        check("pause_restart_lives", lives, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Parametrised game-state controller for the PACMAN design. It generalises the sticky "over" latch and the fixed four-ghost crash check into one block. The block scans N ghosts for collision with the pacman and tracks a lives counter. It sequences IDLE/PLAY/PAUSE/DYING/OVER/WIN, and issues the freeze and respawn controls that the ghost, bean and key-control blocks consume. It sits between the entity-position sources and the display/score logic in the top level.

## Interface
- N_GHOSTS, 4, number of ghosts scanned (1..8)
- LIVES, 3, lives loaded on start (1..7)
- LW, 3, width of lives output; must hold LIVES
- HIT_R, 16, collision half-window in pixels (strict less-than)
- DEATH_TICKS, 60, frame ticks spent in DYING

- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- tick  in  1  one-cycle frame strobe (once per VGA frame)
- start  in  1  one-cycle pulse: begin/restart game
- pause_req  in  1  one-cycle pulse: toggle PLAY/PAUSE
- all_eaten  in  1  level: bean map empty
- pac_x  in  10  pacman x
- pac_y  in  10  pacman y
- ghost_x  in  10*N_GHOSTS  ghost i x at bits [10i+9:10i]
- ghost_y  in  9*N_GHOSTS  ghost i y at bits [9i+8:9i]
- state  out  3  0 IDLE, 1 PLAY, 2 PAUSE, 3 DYING, 4 OVER, 5 WIN
- lives  out  LW  remaining lives
- freeze  out  1  high whenever state != PLAY
- respawn  out  1  one-cycle pulse: entities return to start positions
- over  out  1  high in OVER
- win  out  1  high in WIN
- hit_idx  out  3  index of ghost causing last death

## Operation
- Scanner: index register idx runs 0..N_GHOSTS-1 and wraps to 0. It advances every clk in every state.
- Each cycle, ghost[idx] is compared with the pacman. ghost_y is zero-extended to 10 bits. dx = |pac_x - gx| and dy = |pac_y - gy| are 10-bit unsigned magnitudes, with no wrap.
- hit = (dx < HIT_R) && (dy < HIT_R). hit and idx are registered as hit_q/hit_id_q on the next edge.
- IDLE: on start, go to PLAY, set lives = LIVES, and pulse respawn.
- PLAY: priority order is all_eaten, then hit_q, then pause_req.
  - all_eaten: go to WIN.
  - hit_q: go to DYING, set lives = lives-1, set hit_idx = hit_id_q, clear the death counter.
  - pause_req: go to PAUSE.
- PAUSE: pause_req returns to PLAY. start goes to PLAY, reloads lives and pulses respawn. Hits are ignored.
- DYING: the death counter increments on tick. When it reaches DEATH_TICKS:
  - if lives == 0, go to OVER;
  - otherwise pulse respawn and go to PLAY.
  - start is ignored in DYING.
- OVER and WIN are sticky. start goes to PLAY, reloads lives to LIVES and pulses respawn. All other inputs are ignored.
- hit_q is discarded (not queued) outside PLAY. The first cycle back in PLAY uses freshly registered compares only.
- lives never underflows. Entering DYING with lives 1 gives lives 0 and then OVER.

## Timing
- Reset values: state=IDLE, lives=LIVES, freeze=1, respawn=0, over=0, win=0, hit_idx=0, idx=0, hit_q=0, death counter=0.
- Collision latency: a ghost overlapping the pacman causes DYING at most N_GHOSTS+1 cycles after the overlap begins.
  - Breakdown: up to N_GHOSTS-1 cycles waiting for idx, 1 cycle for the register, 1 cycle for the state update.
- Outputs are registered. freeze, over and win change on the same edge as state.
- respawn is high for exactly one cycle, coincident with the first cycle of PLAY after IDLE/OVER/WIN/DYING exit or a PAUSE restart.
- DYING duration is exactly DEATH_TICKS tick pulses. A tick in the entry cycle is not counted.
- Simultaneous events:
  - all_eaten and hit_q in PLAY: WIN.
  - hit_q and pause_req: DYING.
  - start and pause_req in PAUSE: restart.
- Reset asserted mid-DYING or mid-PAUSE returns all registers to reset values on that edge.

## Test plan
- Reset then start, with ghosts all at (600,400) and pac at (10,10): state=1, lives=3, respawn high for 1 cycle, freeze=0, and no hit over 1000 cycles.
- Ghost 2 moved to (pac_x+15, pac_y-15) in PLAY: state=3 within 5 cycles, lives=2, hit_idx=2. Ghost at dx=16 gives no hit.
- Stay in DYING with DEATH_TICKS=60: 59 ticks keeps state 3; the 60th tick gives state 1 and a respawn pulse. Repeat until lives=0: state=4, over=1, and it stays there 10000 cycles until start.
- all_eaten asserted in the same cycle as hit_q: state=5, win=1, lives unchanged.
- pause_req in PLAY: state=2, freeze=1, and an overlapping ghost causes no death. A second pause_req returns to state 1.
- Reset (rst=0) pulsed during DYING: next cycle state=0, lives=3, all flags 0.
